uart_tx_cfg: RTL and testbench

Parametrised UART transmitter that serialises one word per request. Frame format is configurable at elaboration: data width, parity mode and stop-bit count. It has an explicit ready handshake and asynchronous reset, and is intended as the drop-in transmit path for all UART links in the design. LSB first, line idles high.

---
 rtl/uart_tx_cfg.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with elaboration-time frame format: data width, parity mode, stop bits.
// One word per accepted request, LSB first, line idles high, Done pulses as Ready returns.
module uart_tx_cfg #(
  parameter int unsigned CLOCKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  input  logic                 i_TX_DV,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 2);

  if (CLOCKS_PER_BIT < 2 || CLOCKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_cfg: CLOCKS_PER_BIT out of range 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS out of range 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 active_q;
  logic                 done_q, done_d;
  logic                 bit_end_c;

  assign bit_end_c = (cnt_q == CNT_LAST);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      active_q <= ~ready_d;
      done_q   <= done_d;
    end
  end

  // Serial level is decided one cycle ahead so the line comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_d    = par_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        ready_d  = 1'b1;
        if (i_TX_DV) begin
          sh_d     = i_TX_Byte;
          par_d    = (^i_TX_Byte) ^ ODD_PAR;
          cnt_d    = '0;
          state_d  = S_START;
          serial_d = 1'b0;
          ready_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d  = S_DATA;
          bit_d    = '0;
          serial_d = sh_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            sh_d     = {1'b0, sh_q[DATA_BITS-1:1]};
            serial_d = sh_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d  = S_STOP;
          bit_d    = '0;
          serial_d = 1'b1;
        end
      end
      S_STOP: begin
        serial_d = 1'b1;
        if (bit_end_c) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        ready_d  = 1'b1;
      end
    endcase
  end

  assign o_TX_Ready  = ready_q;
  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four frame formats side by side, hand-computed line patterns
// are queued at request time and a per-cycle monitor compares every frame as it appears.
module tb_uart_tx_cfg;

  localparam int NI = 4;
  // Instances: 0 = 8N1/CPB4, 1 = 7E1/CPB4, 2 = 7O1/CPB4, 3 = 8N2/CPB3.
  localparam int unsigned CPB_T [NI] = '{4, 4, 4, 3};
  localparam int unsigned DB_T  [NI] = '{8, 7, 7, 8};
  localparam int unsigned PAR_T [NI] = '{0, 1, 2, 0};
  localparam int unsigned SB_T  [NI] = '{1, 1, 1, 2};
  localparam int unsigned NB_T  [NI] = '{10, 10, 10, 11};

  // Expected line levels, one per serial bit, bit 0 = start bit.
  typedef struct packed {
    logic        follow;
    logic [15:0] bits;
  } exp_t;

  logic       clk;
  logic       rst_s  [NI];
  logic       dv_s   [NI];
  logic [8:0] byte_s [NI];
  logic       ser_s  [NI];
  logic       rdy_s  [NI];
  logic       act_s  [NI];
  logic       done_s [NI];

  exp_t exp_q [NI][$];
  exp_t cur   [NI];
  bit   busy  [NI];
  int   cyc   [NI];
  int   gap   [NI];

  int n_checks;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_cfg #(
      .CLOCKS_PER_BIT(CPB_T[g]),
      .DATA_BITS     (DB_T[g]),
      .PARITY        (PAR_T[g]),
      .STOP_BITS     (SB_T[g])
    ) u_dut (
      .i_Clk      (clk),
      .i_Rst      (rst_s[g]),
      .i_TX_Byte  (byte_s[g][DB_T[g]-1:0]),
      .i_TX_DV    (dv_s[g]),
      .o_TX_Ready (rdy_s[g]),
      .o_TX_Active(act_s[g]),
      .o_TX_Serial(ser_s[g]),
      .o_TX_Done  (done_s[g])
    );
  end

  task automatic check(input string name, input int g, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t got %0d expected %0d", name, g, $time, act, exp);
  endtask

  // Monitor: pops the expected frame when Ready drops and follows it cycle by cycle.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      int f;
      f = int'(NB_T[g] * CPB_T[g]);
      if (rst_s[g]) begin
        check("rst_serial", g, int'(ser_s[g]), 1);
        check("rst_ready", g, int'(rdy_s[g]), 1);
        check("rst_active", g, int'(act_s[g]), 0);
        check("rst_done", g, int'(done_s[g]), 0);
        busy[g] = 1'b0;
        gap[g]  = 2;
      end else begin
        if (!busy[g] && !rdy_s[g]) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame inst%0d t=%0t got frame start expected idle", g, $time);
            cur[g] = '{follow: 1'b0, bits: 16'hFFFF};
          end else begin
            cur[g] = exp_q[g].pop_front();
            if (cur[g].follow) check("b2b_gap", g, gap[g], 0);
          end
          busy[g] = 1'b1;
          cyc[g]  = 0;
        end
        if (busy[g]) begin
          if (cyc[g] < f) begin
            check("busy_ready", g, int'(rdy_s[g]), 0);
            check("busy_active", g, int'(act_s[g]), 1);
            check("busy_done", g, int'(done_s[g]), 0);
            check("serial_bit", g, int'(ser_s[g]), int'(cur[g].bits[cyc[g] / int'(CPB_T[g])]));
            cyc[g]++;
          end else begin
            check("done_pulse", g, int'(done_s[g]), 1);
            check("done_ready", g, int'(rdy_s[g]), 1);
            check("done_active", g, int'(act_s[g]), 0);
            busy[g] = 1'b0;
            gap[g]  = 0;
          end
        end else begin
          check("idle_serial", g, int'(ser_s[g]), 1);
          check("idle_done", g, int'(done_s[g]), 0);
          check("idle_active", g, int'(act_s[g]), 0);
          gap[g]++;
        end
      end
    end
  end

  // Returns just after the clock edge that accepts the pending request.
  task automatic wait_accept(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rdy_s[g]) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", g, int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [8:0] w, input logic [15:0] bits);
    exp_q[g].push_back('{follow: 1'b0, bits: bits});
    @(posedge clk);
    #1;
    byte_s[g] = w;
    dv_s[g]   = 1'b1;
    wait_accept(g);
    dv_s[g]   = 1'b0;
    byte_s[g] = ~w;
  endtask

  task automatic wait_idle(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (!busy[g] && rdy_s[g] && exp_q[g].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", g, int'(ok), 1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int g = 0; g < NI; g++) begin
      rst_s[g]  = 1'b1;
      dv_s[g]   = 1'b0;
      byte_s[g] = 9'h000;
      busy[g]   = 1'b0;
      cyc[g]    = 0;
      gap[g]    = 2;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) rst_s[g] = 1'b0;
    repeat (2) @(posedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(0, 9'h0A5, 16'h034A);
    wait_idle(0);

    // 7E1: 0x55 parity 0, 0x07 parity 1
    send(1, 9'h055, 16'h02AA);
    wait_idle(1);
    send(1, 9'h007, 16'h030E);
    wait_idle(1);

    // 7O1: 0x55 parity 1, 0x07 parity 0
    send(2, 9'h055, 16'h03AA);
    wait_idle(2);
    send(2, 9'h007, 16'h020E);
    wait_idle(2);

    // 8N2 CPB3: 0x3C with two stop bits
    send(3, 9'h03C, 16'h0678);
    wait_idle(3);

    // Back-to-back: DV held high across the first Done cycle.
    exp_q[0].push_back('{follow: 1'b0, bits: 16'h0202});
    exp_q[0].push_back('{follow: 1'b1, bits: 16'h0300});
    @(posedge clk);
    #1;
    byte_s[0] = 9'h001;
    dv_s[0]   = 1'b1;
    wait_accept(0);
    byte_s[0] = 9'h080;
    wait_accept(0);
    dv_s[0]   = 1'b0;
    byte_s[0] = 9'h1FF;
    wait_idle(0);

    // Request while busy is dropped.
    send(0, 9'h000, 16'h0200);
    repeat (10) @(posedge clk);
    #1;
    byte_s[0] = 9'h0FF;
    dv_s[0]   = 1'b1;
    @(posedge clk);
    #1;
    dv_s[0]   = 1'b0;
    wait_idle(0);

    // Reset during data bit 3 aborts the frame; the next frame is clean.
    send(0, 9'h0A5, 16'h034A);
    repeat (17) @(posedge clk);
    #1;
    rst_s[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    wait_idle(0);
    send(0, 9'h03C, 16'h0278);
    wait_idle(0);

    repeat (5) @(posedge clk);
    #2;
    for (int g = 0; g < NI; g++) check("queue_empty", g, exp_q[g].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
